// File: rtl/fetch_unit.sv
// Instruction-fetch control: next-PC selection, imem request issue, and an
// in-order queue of returned instructions presented to decode.
module fetch_unit #(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter int unsigned     MAX_OUTST    = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST) + 1;

  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    alloc_q, alloc_d;
  logic [OW-1:0]    pend_q, pend_d;
  logic [OW-1:0]    drop_q, drop_d;

  logic          issue, pop, do_drop, do_fill;
  logic [AW-1:0] fill_idx;
  logic [OW:0]   outst, dsum;

  // Oldest unfilled entry sits just past the filled prefix of the queue.
  assign fill_idx  = head_q + AW'(alloc_q - CW'(pend_q));
  assign outst     = {1'b0, pend_q} + {1'b0, drop_q};
  assign imem_req  = !rst && !redirect_valid && (alloc_q < CW'(DEPTH)) &&
                     (outst < (OW+1)'(MAX_OUTST));
  assign imem_addr = {pc[WIDTH-1:2], 2'b00};
  assign issue     = imem_req & imem_gnt;
  assign do_drop   = imem_rvalid && (drop_q != '0);
  assign do_fill   = imem_rvalid && (drop_q == '0) && (pend_q != '0);

  assign instr_valid = filled_q[head_q] && (alloc_q != '0) && !redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign instr       = instr_q[head_q];
  assign instr_pc    = pc_q[head_q];

  always_comb begin
    pc_next = pc;
    if (rst)                 pc_next = RESET_VECTOR;
    else if (redirect_valid) pc_next = redirect_target & ~WIDTH'(3);
    else if (issue)          pc_next = pc + WIDTH'(4);
  end

  always_comb begin
    dsum    = {1'b0, drop_q} + {1'b0, pend_q};
    alloc_d = alloc_q + CW'(issue) - CW'(pop);
    pend_d  = pend_q + OW'(issue) - OW'(do_fill);
    drop_d  = drop_q - OW'(do_drop);
    if (redirect_valid) begin
      alloc_d = '0;
      pend_d  = '0;
      // Responses still owed become drops, minus one arriving right now.
      drop_d  = OW'((imem_rvalid && dsum != '0) ? dsum - (OW+1)'(1) : dsum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      alloc_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else if (redirect_valid) begin
      head_q   <= '0;
      tail_q   <= '0;
      alloc_q  <= alloc_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      filled_q <= '0;
    end else begin
      alloc_q <= alloc_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + AW'(1);
      end
      if (issue) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + AW'(1);
      end
      if (do_fill) filled_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (issue)   pc_q[tail_q]      <= pc;
      if (do_fill) instr_q[fill_idx] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC register, in-order memory with optional
// response hold, and a record of every instruction handed to decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        hold;
  logic [31:0] mq  [$];
  logic [31:0] dpc [$];
  logic [31:0] dins[$];
  int          n_issue;
  int          tests_run    = 0;
  int          tests_failed = 0;

  fetch_unit #(
    .WIDTH(32),
    .DEPTH(4),
    .MAX_OUTST(2),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .pc_next(pc_next),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc <= pc_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes, advance the edge, then present the memory
  // response for the next cycle (1-cycle latency unless held).
  task automatic step();
    logic        iss;
    logic [31:0] a;
    #1;
    iss = imem_req & imem_gnt;
    a   = imem_addr;
    if (instr_valid & instr_ready) begin
      dpc.push_back(instr_pc);
      dins.push_back(instr);
    end
    if (iss) n_issue++;
    @(posedge clk);
    if (rst) mq.delete();
    else if (iss) mq.push_back(a);
    @(negedge clk);
    if (!hold && mq.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; hold = 1'b0;
    step();
    step();
    rst = 1'b0;
    dpc.delete(); dins.delete(); n_issue = 0;
  endtask

  function automatic logic [31:0] dpc_at(input int i);
    return (dpc.size() > i) ? dpc[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dins_at(input int i);
    return (dins.size() > i) ? dins[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Reset held two cycles, then release.
    do_reset();
    rst = 1'b1;
    #1;
    check("rst_pc_next", pc_next, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    rst = 1'b0;
    #1;
    check("rel_addr", imem_addr, 32'h0);
    check("rel_req", {31'b0, imem_req}, 32'h1);

    // Grant stall: request held, PC frozen, then one grant advances by 4.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_pcn", pc_next, pc);
      check("stall_addr", imem_addr, 32'h0);
      step();
    end
    imem_gnt = 1'b1;
    #1;
    check("stall_gnt_pcn", pc_next, 32'h4);
    step();
    imem_gnt = 1'b0;
    #1;
    check("stall_pc", pc, 32'h4);

    // Streaming with 1-cycle memory.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("stream_issues", n_issue, 12);
    check("stream_count", dpc.size(), 10);
    for (int i = 0; i < 8; i++) begin
      check("stream_pc", dpc_at(i), 32'(4 * i));
      check("stream_instr", dins_at(i), mem_word(32'(4 * i)));
    end

    // Outstanding limit: responses held, only two requests go out.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; hold = 1'b1;
    step();
    step();
    #1;
    check("outst_req", {31'b0, imem_req}, 32'h0);
    check("outst_pc", pc, 32'h8);

    // Backpressure fills the queue.
    do_reset();
    imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #1;
    check("full_req", {31'b0, imem_req}, 32'h0);
    check("full_pcn", pc_next, 32'h10);
    check("full_pc", pc, 32'h10);
    check("full_head", instr_pc, 32'h0);
    check("full_valid", {31'b0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    check("bp_pop_pc", dpc_at(0), 32'h0);
    check("bp_req", {31'b0, imem_req}, 32'h1);
    check("bp_addr", imem_addr, 32'h10);

    // Redirect with two outstanding; both late responses are discarded.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; hold = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_target = 32'h103;
    #1;
    check("rd1_pcn", pc_next, 32'h100);
    check("rd1_req", {31'b0, imem_req}, 32'h0);
    step();
    redirect_valid = 1'b0; hold = 1'b0;
    #1;
    check("rd1_drop_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 8; i++) step();
    check("rd1_first_pc", dpc_at(0), 32'h100);
    check("rd1_first_instr", dins_at(0), mem_word(32'h100));

    // Redirect on the same cycle as a response: only one more drop.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; hold = 1'b1;
    step();
    step();
    hold = 1'b0;
    step();
    check("rd2_rvalid", {31'b0, imem_rvalid}, 32'h1);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    #1;
    check("rd2_pcn", pc_next, 32'h40);
    step();
    redirect_valid = 1'b0;
    #1;
    check("rd2_req", {31'b0, imem_req}, 32'h1);
    check("rd2_addr", imem_addr, 32'h40);
    for (int i = 0; i < 6; i++) step();
    check("rd2_first_pc", dpc_at(0), 32'h40);
    check("rd2_first_instr", dins_at(0), mem_word(32'h40));
    check("rd2_second_pc", dpc_at(1), 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
